// File: rtl/credit_tx_unit_pkg.sv
// Shared link parameters for the PE-to-router transmitter and the router input buffers.
// Router buffer depth and transmitter credits both come from here so they cannot drift apart.
package credit_tx_unit_pkg;

   // Flit width on the router links.
   localparam int ROUTER_WIDTH          = 16;

   // Downstream input-buffer depth, which is also the transmitter credit reset value.
   localparam int CREDIT_INIT_DEFAULT   = 2;

   // Depth of the local flit FIFO inside the transmitter.
   localparam int TX_FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/credit_tx_unit_sync_fifo.sv
// SyncFifo: single-clock FIFO with a combinational head read and registered full/empty flags.
// Reset is synchronous and active-low. DEPTH must be a power of two so the pointers wrap
// naturally. Push while full and pop while empty are ignored. This block is also intended
// for reuse by the router input units.
module SyncFifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic [CW-1:0]    w_count_next;
   logic             w_push;
   logic             w_pop;

   assign w_push = push && !r_full;
   assign w_pop  = pop && !r_empty;

   // Next occupancy. A simultaneous push and pop leaves it unchanged.
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Storage write. It is left unreset so the array maps onto plain memory.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and the registered status flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_next;
         r_full  <= (w_count_next == CW'(DEPTH));
         r_empty <= (w_count_next == '0);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/credit_tx_unit.sv
// credit_tx_unit: credit-based flit transmitter from a PE into one router input port.
// PE flits are queued in a SyncFifo. A flit launches only while a credit is held, and every
// tx_credit pulse returns one credit. Optional checking is enabled by the macro
// CREDIT_TX_CHECK_EN, which gives a sticky credit_err flag and an overflow assertion.
// Without the macro, credit_err is tied low. Counter saturation is present in both builds.
module credit_tx_unit
   import credit_tx_unit_pkg::*;
#(
   parameter int CREDIT_INIT = CREDIT_INIT_DEFAULT,
   parameter int FIFO_DEPTH  = TX_FIFO_DEPTH_DEFAULT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             pe_valid,
   input  logic [ROUTER_WIDTH-1:0]          pe_data,
   output logic                             pe_ready,
   output logic                             tx_data_valid,
   output logic [ROUTER_WIDTH-1:0]          tx_data,
   input  logic                             tx_credit,
   output logic [$clog2(CREDIT_INIT+1)-1:0] credit_count,
   output logic                             fifo_empty,
   output logic                             credit_err
);

   localparam int CW = $clog2(CREDIT_INIT + 1);

   logic [CW-1:0]           r_credit;
   logic [CW-1:0]           w_credit_next;
   logic                    r_tx_valid;
   logic [ROUTER_WIDTH-1:0] r_tx_data;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic [ROUTER_WIDTH-1:0] w_fifo_head;
   logic                    w_push;
   logic                    w_pop;

   // pe_ready comes only from the registered full flag, so a pop in the same cycle
   // does not open a slot.
   assign w_push = pe_valid && !w_fifo_full;
   assign w_pop  = !w_fifo_empty && (r_credit != '0);

   SyncFifo #(
      .WIDTH (ROUTER_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (pe_data),
      .dout  (w_fifo_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   // Credit arithmetic: subtract one on a pop, add one on a returned credit,
   // and saturate at CREDIT_INIT.
   always_comb begin
      w_credit_next = r_credit;
      if (w_pop && !tx_credit) begin
         w_credit_next = r_credit - CW'(1);
      end else if (!w_pop && tx_credit && (r_credit != CW'(CREDIT_INIT))) begin
         w_credit_next = r_credit + CW'(1);
      end
   end

   // Credit counter. Returned credits are ignored during reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_credit <= CW'(CREDIT_INIT);
      end else begin
         r_credit <= w_credit_next;
      end
   end

   // Launch register: valid pulses for one cycle per pop, and the data holds between flits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_tx_valid <= w_pop;
         if (w_pop) r_tx_data <= w_fifo_head;
      end
   end

`ifdef CREDIT_TX_CHECK_EN
   logic w_overflow;
   logic r_credit_err;

   assign w_overflow = tx_credit && !w_pop && (r_credit == CW'(CREDIT_INIT));

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_credit_err <= 1'b0;
      end else if (w_overflow) begin
         r_credit_err <= 1'b1;
      end
   end

   assign credit_err = r_credit_err;

   a_no_credit_overflow : assert property (@(posedge clk) disable iff (!rst) !w_overflow)
      else $warning("credit_tx_unit: credit returned while counter full");
`else
   assign credit_err = 1'b0;
`endif

   assign pe_ready      = !w_fifo_full;
   assign tx_data_valid = r_tx_valid;
   assign tx_data       = r_tx_data;
   assign credit_count  = r_credit;
   assign fifo_empty    = w_fifo_empty;

endmodule

// File: tb/tb_credit_tx_unit.sv
// Testbench for credit_tx_unit: directed scenarios with literal expectations, plus a queue-based
// behavioural model that is compared against every output on every cycle.
module tb_credit_tx_unit;
   import credit_tx_unit_pkg::*;

   localparam int CI = 2;
   localparam int FD = 4;
   localparam int RW = ROUTER_WIDTH;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pe_valid = 1'b0;
   logic [RW-1:0] pe_data = '0;
   logic          pe_ready;
   logic          tx_data_valid;
   logic [RW-1:0] tx_data;
   logic          tx_credit = 1'b0;
   logic [1:0]    credit_count;
   logic          fifo_empty;
   logic          credit_err;

   int n_checks = 0;
   int n_fail   = 0;

   credit_tx_unit #(.CREDIT_INIT(CI), .FIFO_DEPTH(FD)) dut (
      .clk           (clk),
      .rst           (rst),
      .pe_valid      (pe_valid),
      .pe_data       (pe_data),
      .pe_ready      (pe_ready),
      .tx_data_valid (tx_data_valid),
      .tx_data       (tx_data),
      .tx_credit     (tx_credit),
      .credit_count  (credit_count),
      .fifo_empty    (fifo_empty),
      .credit_err    (credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: an ordered queue of accepted flits and an integer credit balance.
   logic [RW-1:0] q[$];
   int            m_cred    = CI;
   bit            m_err     = 1'b0;
   bit            m_valid   = 1'b0;
   logic [RW-1:0] m_data    = '0;
   bit            m_started = 1'b0;

   always @(posedge clk) begin : model
      bit do_pop;
      bit do_push;
      if (!rst) begin
         q.delete();
         m_cred    = CI;
         m_err     = 1'b0;
         m_valid   = 1'b0;
         m_data    = '0;
         m_started = 1'b1;
      end else begin
         do_pop  = (q.size() > 0) && (m_cred > 0);
         do_push = pe_valid && (q.size() < FD);
         m_valid = do_pop;
         if (do_pop) m_data = q.pop_front();
         if (do_push) q.push_back(pe_data);
`ifdef CREDIT_TX_CHECK_EN
         if (tx_credit && !do_pop && m_cred == CI) m_err = 1'b1;
`endif
         m_cred = m_cred - int'(do_pop) + int'(tx_credit);
         if (m_cred > CI) m_cred = CI;
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (m_started) begin
         chk("m_tx_valid", 32'(tx_data_valid), 32'(m_valid));
         chk("m_tx_data", 32'(tx_data), 32'(m_data));
         chk("m_pe_ready", 32'(pe_ready), 32'(q.size() < FD));
         chk("m_fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
         chk("m_credit", 32'(credit_count), 32'(m_cred));
         chk("m_credit_err", 32'(credit_err), 32'(m_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int            out_cyc[$];
      logic [RW-1:0] out_dat[$];
      bit            acc;

      // Reset, then a single flit.
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      chk("rst_credit", 32'(credit_count), 32'd2);
      chk("rst_empty", 32'(fifo_empty), 32'd1);
      chk("rst_ready", 32'(pe_ready), 32'd1);
      chk("rst_valid", 32'(tx_data_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_err", 32'(credit_err), 32'd0);
      pe_valid = 1'b1; pe_data = 16'h00A5;            // cycle 0
      step(); pe_valid = 1'b0;                        // cycle 1
      chk("single_c1_valid", 32'(tx_data_valid), 32'd0);
      step();                                         // cycle 2
      chk("single_valid", 32'(tx_data_valid), 32'd1);
      chk("single_data", 32'(tx_data), 32'h00A5);
      chk("single_credit", 32'(credit_count), 32'd1);
      step();
      chk("single_pulse_end", 32'(tx_data_valid), 32'd0);
      tx_credit = 1'b1; step(); tx_credit = 1'b0;
      chk("refill_credit", 32'(credit_count), 32'd2);
      $display("txn single flit 0xA5 done");

      // Credit exhaustion: four back-to-back pushes with no returned credits.
      for (int c = 0; c < 8; c++) begin
         pe_valid = (c < 4);
         pe_data  = RW'(16'h10 + c);
         if (tx_data_valid) begin out_cyc.push_back(c); out_dat.push_back(tx_data); end
         step();
      end
      pe_valid = 1'b0;
      chk("exh_count", 32'(out_cyc.size()), 32'd2);
      if (out_cyc.size() == 2) begin
         chk("exh_cyc0", 32'(out_cyc[0]), 32'd2);
         chk("exh_cyc1", 32'(out_cyc[1]), 32'd3);
         chk("exh_dat0", 32'(out_dat[0]), 32'h10);
         chk("exh_dat1", 32'(out_dat[1]), 32'h11);
      end
      chk("exh_credit", 32'(credit_count), 32'd0);
      chk("exh_not_empty", 32'(fifo_empty), 32'd0);
      chk("exh_ready", 32'(pe_ready), 32'd1);
      $display("txn credit exhaustion: %0d flits out", out_cyc.size());

      // Credit return: one pulse in cycle M=0 releases one flit in cycle 2.
      out_cyc.delete(); out_dat.delete();
      for (int c = 0; c < 5; c++) begin
         tx_credit = (c == 0);
         if (tx_data_valid) begin out_cyc.push_back(c); out_dat.push_back(tx_data); end
         step();
      end
      tx_credit = 1'b0;
      chk("ret_count", 32'(out_cyc.size()), 32'd1);
      if (out_cyc.size() == 1) begin
         chk("ret_cyc", 32'(out_cyc[0]), 32'd2);
         chk("ret_dat", 32'(out_dat[0]), 32'h12);
      end
      chk("ret_credit", 32'(credit_count), 32'd0);
      out_cyc.delete(); out_dat.delete();
      for (int c = 0; c < 6; c++) begin
         tx_credit = (c < 2);
         if (tx_data_valid) begin out_cyc.push_back(c); out_dat.push_back(tx_data); end
         step();
      end
      tx_credit = 1'b0;
      chk("ret2_count", 32'(out_cyc.size()), 32'd1);
      if (out_cyc.size() == 1) chk("ret2_dat", 32'(out_dat[0]), 32'h13);
      chk("ret2_credit", 32'(credit_count), 32'd1);
      chk("ret2_empty", 32'(fifo_empty), 32'd1);
      $display("txn credit return done, credit=%0d", credit_count);

      // Full FIFO and ordering. First spend the remaining credit.
      pe_valid = 1'b1; pe_data = 16'h20; step(); pe_valid = 1'b0;
      repeat (3) step();
      chk("full_pre_credit", 32'(credit_count), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         pe_valid = 1'b1; pe_data = RW'(k); acc = 1'b0;
         for (int t = 0; t < 6 && !acc; t++) begin
            if (pe_ready) acc = 1'b1;
            step();
         end
         if (k < 5) chk("full_accept", 32'(acc), 32'd1);
      end
      chk("full_ready_low", 32'(pe_ready), 32'd0);
      chk("full_pe_holds", 32'(pe_valid), 32'd1);
      out_cyc.delete(); out_dat.delete();
      for (int c = 0; c < 20; c++) begin
         tx_credit = (c < 5);
         if (tx_data_valid) begin out_cyc.push_back(c); out_dat.push_back(tx_data); end
         acc = pe_valid && pe_ready;
         step();
         if (acc) pe_valid = 1'b0;
      end
      tx_credit = 1'b0; pe_valid = 1'b0;
      chk("order_count", 32'(out_dat.size()), 32'd5);
      for (int i = 0; i < out_dat.size() && i < 5; i++) chk("order_data", 32'(out_dat[i]), 32'(i + 1));
      chk("order_credit", 32'(credit_count), 32'd0);
      $display("txn full/order: %0d flits out", out_dat.size());

      // Simultaneous pop and credit at credit_count=1.
      pe_valid = 1'b1; pe_data = 16'h30; tx_credit = 1'b1; step();
      pe_valid = 1'b0;
      chk("sim_pre_credit", 32'(credit_count), 32'd1);
      chk("sim_pre_empty", 32'(fifo_empty), 32'd0);
      tx_credit = 1'b1; step(); tx_credit = 1'b0;
      chk("sim_valid", 32'(tx_data_valid), 32'd1);
      chk("sim_data", 32'(tx_data), 32'h30);
      chk("sim_credit", 32'(credit_count), 32'd1);
      $display("txn simultaneous pop+credit done");

      // Overflow: fill to CREDIT_INIT, then return one more credit.
      tx_credit = 1'b1; step(); tx_credit = 1'b0;
      chk("ovf_pre_credit", 32'(credit_count), 32'd2);
      chk("ovf_pre_err", 32'(credit_err), 32'd0);
      tx_credit = 1'b1; step(); tx_credit = 1'b0;
      chk("ovf_credit", 32'(credit_count), 32'd2);
`ifdef CREDIT_TX_CHECK_EN
      chk("ovf_err", 32'(credit_err), 32'd1);
      repeat (3) step();
      chk("ovf_err_sticky", 32'(credit_err), 32'd1);
`else
      chk("ovf_err_off", 32'(credit_err), 32'd0);
      repeat (3) step();
      chk("ovf_err_off_later", 32'(credit_err), 32'd0);
`endif
      rst = 1'b0; tx_credit = 1'b1; step(); tx_credit = 1'b0; rst = 1'b1;
      chk("rst2_err", 32'(credit_err), 32'd0);
      chk("rst2_credit", 32'(credit_count), 32'd2);
      $display("txn overflow and reset done");

      step();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
